// File: rtl/timebase_scheduler_if.sv
// Control and status bundle for the timebase scheduler: run/mode/resync
// controls in, tick pulses, counters and display-select out.
interface timebase_scheduler_if;
  logic       en;
  logic       fast;
  logic       resync;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       blink;
  logic [5:0] sec_cnt;
  logic       tick_min;
  logic       tick_refresh;
  logic [1:0] mux_sel;

  modport master (
    output en, fast, resync,
    input  tick_1hz, tick_2hz, blink, sec_cnt, tick_min, tick_refresh, mux_sel
  );

  modport slave (
    input  en, fast, resync,
    output tick_1hz, tick_2hz, blink, sec_cnt, tick_min, tick_refresh, mux_sel
  );
endinterface

// File: rtl/timebase_scheduler.sv
// Second/half-second timebase with seconds counter, blink level and a
// free-running display refresh prescaler driving the digit select.
module timebase_scheduler #(
  parameter int unsigned SEC_DIV     = 100000000,
  parameter int unsigned FAST_DIV    = 1000000,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  timebase_scheduler_if.slave  bus
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [31:0]   SEC_LAST  = 32'(SEC_DIV - 1);
  localparam logic [31:0]   SEC_HALF  = 32'(SEC_DIV / 2 - 1);
  localparam logic [31:0]   FAST_LAST = 32'(FAST_DIV - 1);
  localparam logic [31:0]   FAST_HALF = 32'(FAST_DIV / 2 - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

  logic [31:0]   pre;
  logic [31:0]   period_last;
  logic [31:0]   half_last;
  logic [RW-1:0] ref_cnt;

  always_comb begin
    period_last = SEC_LAST;
    half_last   = SEC_HALF;
    if (bus.fast) begin
      period_last = FAST_LAST;
      half_last   = FAST_HALF;
    end
  end

  // Refresh path ignores en/fast/resync so the display never stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_cnt          <= '0;
      bus.tick_refresh <= 1'b0;
      bus.mux_sel      <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt          <= '0;
      bus.tick_refresh <= 1'b1;
      bus.mux_sel      <= bus.mux_sel + 2'd1;
    end else begin
      ref_cnt          <= ref_cnt + RW'(1);
      bus.tick_refresh <= 1'b0;
    end
  end

  // >= on the terminal compare catches a period shortened by fast mid-count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre          <= '0;
      bus.tick_1hz <= 1'b0;
      bus.tick_2hz <= 1'b0;
      bus.tick_min <= 1'b0;
      bus.blink    <= 1'b0;
      bus.sec_cnt  <= '0;
    end else if (bus.resync) begin
      pre          <= '0;
      bus.tick_1hz <= 1'b0;
      bus.tick_2hz <= 1'b0;
      bus.tick_min <= 1'b0;
      bus.blink    <= 1'b0;
    end else if (!bus.en) begin
      bus.tick_1hz <= 1'b0;
      bus.tick_2hz <= 1'b0;
      bus.tick_min <= 1'b0;
    end else if (pre >= period_last) begin
      pre          <= '0;
      bus.tick_1hz <= 1'b1;
      bus.tick_2hz <= 1'b1;
      bus.blink    <= ~bus.blink;
      if (bus.sec_cnt == 6'd59) begin
        bus.sec_cnt  <= '0;
        bus.tick_min <= 1'b1;
      end else begin
        bus.sec_cnt  <= bus.sec_cnt + 6'd1;
        bus.tick_min <= 1'b0;
      end
    end else if (pre == half_last) begin
      pre          <= pre + 32'd1;
      bus.tick_1hz <= 1'b0;
      bus.tick_2hz <= 1'b1;
      bus.tick_min <= 1'b0;
      bus.blink    <= ~bus.blink;
    end else begin
      pre          <= pre + 32'd1;
      bus.tick_1hz <= 1'b0;
      bus.tick_2hz <= 1'b0;
      bus.tick_min <= 1'b0;
    end
  end

endmodule

// File: doc/timebase_scheduler.md
TIMEBASE_SCHEDULER -- requirements
Module: timebase_scheduler

Interface
REQ-001 Parameter SEC_DIV, default 100000000: clk cycles per 1 Hz tick; even, >= 4.
REQ-002 Parameter FAST_DIV, default 1000000: clk cycles per tick in fast mode; even, >= 2, < SEC_DIV.
REQ-003 Parameter REFRESH_DIV, default 100000: clk cycles per display-refresh tick; >= 2.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  1 = timebase runs; 0 = second path frozen.
REQ-007 fast  input  1  1 = second period is FAST_DIV (time-set/test mode).
REQ-008 resync  input  1  single-cycle request to restart the second phase.
REQ-009 tick_1hz  output  1  one-cycle pulse per second period.
REQ-010 tick_2hz  output  1  one-cycle pulse at half-period and at full period.
REQ-011 blink  output  1  level toggled on every tick_2hz (1 Hz square, 50% duty).
REQ-012 sec_cnt  output  6  seconds count 0..59.
REQ-013 tick_min  output  1  one-cycle pulse when sec_cnt wraps 59->0.
REQ-014 tick_refresh  output  1  one-cycle pulse every REFRESH_DIV cycles.
REQ-015 mux_sel  output  2  display digit select, advances on tick_refresh.

Function
REQ-016 Prescaler pre (32 bit) counts 0..T-1; T = FAST_DIV when fast=1, else SEC_DIV.
REQ-017 en=1, resync=0, pre >= T-1: next cycle pre<=0, tick_1hz<=1, tick_2hz<=1 (>= handles fast switched on mid-period).
REQ-018 en=1, resync=0, pre == T/2-1: next cycle pre<=pre+1, tick_2hz<=1, tick_1hz<=0.
REQ-019 Otherwise with en=1, resync=0: pre<=pre+1, tick_1hz<=0, tick_2hz<=0.
REQ-020 All tick outputs are registered and high for exactly one clk cycle per event; no combinational path from inputs to outputs.
REQ-021 First tick_1hz after reset release with en=1 is high in cycle T (cycle 1 = first cycle with rst=1).
REQ-022 blink toggles in the same edge that asserts tick_2hz.
REQ-023 sec_cnt increments on the edge that asserts tick_1hz; at 59 it becomes 0 and tick_min asserts in the same cycle as that tick_1hz.
REQ-024 en=0: pre, sec_cnt, blink hold; tick_1hz, tick_2hz, tick_min forced 0; pending terminal count resumes when en returns.
REQ-025 resync=1 (any en, any fast): next cycle pre<=0, blink<=0, tick_1hz/tick_2hz/tick_min<=0; sec_cnt held; resync beats a coincident terminal count (tick suppressed).
REQ-026 Refresh prescaler (width fits REFRESH_DIV) free-runs independent of en, fast, resync; at REFRESH_DIV-1 wraps to 0, tick_refresh<=1.
REQ-027 mux_sel increments on the edge asserting tick_refresh; 3 wraps to 0.
REQ-028 fast changes take effect on the next compare; no tick is lost or duplicated beyond REQ-017.

Reset
REQ-029 rst=0 at a clk edge: pre=0, refresh prescaler=0, sec_cnt=0, blink=0, mux_sel=0, all tick outputs=0; overrides en, fast, resync.
REQ-030 Reset asserted mid-period discards the partial count; behaviour after release is identical to power-up.

Verification (SEC_DIV=10, FAST_DIV=4, REFRESH_DIV=3)
REQ-031 Release rst, en=1 -> tick_2hz in cycles 5,10,15,20; tick_1hz in cycles 10,20; blink 1 over cycles 5-9, 0 over 10-14.
REQ-032 en=1 for 600 cycles -> sec_cnt reaches 59 at cycle 590; cycle 600 sec_cnt=0, tick_1hz=1, tick_min=1 together.
REQ-033 en=0 for 7 cycles starting at pre=8 -> no ticks while paused; tick_1hz 2 cycles after en returns; refresh ticks unaffected throughout.
REQ-034 resync in the cycle pre=9 -> no tick_1hz; next tick_1hz 10 cycles later; sec_cnt unchanged; blink=0.
REQ-035 fast raised at pre=7 -> next cycle pre=0 with tick_1hz=1; thereafter tick_1hz every 4 cycles, tick_2hz every 2.
REQ-036 Free run -> tick_refresh every 3rd cycle; mux_sel sequence 0,1,2,3,0; rst=0 mid-run -> all outputs 0 next cycle.
